// File: rtl/branch_history_table.sv
// Table of 2-bit saturating branch predictors indexed by PC[INDEX_BITS+1:2], with branch/mispredict statistics.
// Optional branch target buffer enabled by defining BHT_BTB_EN.
module branch_history_table #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              LOOKUP_VALID,
    input  logic [ADDR_W-1:0] LOOKUP_PC,
    output logic              PREDICT_TAKEN,
    input  logic              UPDATE_VALID,
    input  logic [ADDR_W-1:0] UPDATE_PC,
    input  logic              UPDATE_TAKEN,
    input  logic              UPDATE_PREDICTED,
    input  logic [ADDR_W-1:0] UPDATE_TARGET,
    output logic              MISPREDICT,
    input  logic [ADDR_W-1:0] FETCH_PC,
    output logic              BTB_HIT,
    output logic [ADDR_W-1:0] BTB_TARGET,
    output logic [31:0]       BRANCH_COUNT,
    output logic [31:0]       MISPREDICT_COUNT
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_W - INDEX_BITS - 2;

    logic [1:0]            ctr [ENTRIES];
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic                  do_update;
    logic                  unused_pc_bits;

    assign lookup_idx = LOOKUP_PC[INDEX_BITS+1:2];
    assign update_idx = UPDATE_PC[INDEX_BITS+1:2];
    assign do_update  = UPDATE_VALID & ~STALL;

    // Word-aligned PCs: low bits (and, without the BTB, the tag/target inputs) are don't-care.
    assign unused_pc_bits = ^{LOOKUP_PC, UPDATE_PC, FETCH_PC, UPDATE_TARGET};

    assign PREDICT_TAKEN = LOOKUP_VALID & ctr[lookup_idx][1];
    assign MISPREDICT    = UPDATE_VALID & (UPDATE_TAKEN != UPDATE_PREDICTED);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (do_update) begin
            if (UPDATE_TAKEN) begin
                if (ctr[update_idx] != 2'b11) ctr[update_idx] <= ctr[update_idx] + 2'd1;
            end else begin
                if (ctr[update_idx] != 2'b00) ctr[update_idx] <= ctr[update_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            BRANCH_COUNT     <= '0;
            MISPREDICT_COUNT <= '0;
        end else if (do_update) begin
            if (BRANCH_COUNT != 32'hFFFF_FFFF) BRANCH_COUNT <= BRANCH_COUNT + 32'd1;
            if (MISPREDICT && (MISPREDICT_COUNT != 32'hFFFF_FFFF))
                MISPREDICT_COUNT <= MISPREDICT_COUNT + 32'd1;
        end
    end

`ifdef BHT_BTB_EN
    logic                  btb_valid  [ENTRIES];
    logic [TAG_W-1:0]      btb_tag    [ENTRIES];
    logic [ADDR_W-1:0]     btb_target [ENTRIES];
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_W-1:0]      fetch_tag;

    assign fetch_idx = FETCH_PC[INDEX_BITS+1:2];
    assign fetch_tag = FETCH_PC[ADDR_W-1:INDEX_BITS+2];

    // Only taken branches allocate; a not-taken resolve keeps the last known target.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (do_update && UPDATE_TAKEN) begin
            btb_valid[update_idx]  <= 1'b1;
            btb_tag[update_idx]    <= UPDATE_PC[ADDR_W-1:INDEX_BITS+2];
            btb_target[update_idx] <= UPDATE_TARGET;
        end
    end

    assign BTB_HIT    = btb_valid[fetch_idx] & (btb_tag[fetch_idx] == fetch_tag) & ctr[fetch_idx][1];
    assign BTB_TARGET = BTB_HIT ? btb_target[fetch_idx] : '0;
`else
    assign BTB_HIT    = 1'b0;
    assign BTB_TARGET = '0;
`endif

endmodule
